// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - serial 4-slot TDM receiver with frame-sync hunt/lock
module tdm_demux_rx #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bit_en,
  input  logic           d,
  input  logic           fs,
  output logic [4*W-1:0] f,
  output logic           frame_valid,
  output logic           locked,
  output logic           sync_err
);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  logic [0:0]          state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]          slot_q, slot_d;
  // Holds the first W-1 bits of the slot; the last bit arrives straight from d.
  logic [W-2:0]        shreg_q, shreg_d;
  logic [2:0][W-1:0]   stage_q, stage_d;
  logic [4*W-1:0]      f_q, f_d;
  logic                fv_q, fv_d;
  logic                serr_q, serr_d;

  logic [W-1:0]        word;
  logic                take;
  logic                at_bound;
  logic [BW-1:0]       cur_bit;
  logic [1:0]          cur_slot;

  // Next-state: sync checking first, then bit accumulation and word/frame writes.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    slot_d    = slot_q;
    shreg_d   = shreg_q;
    stage_d   = stage_q;
    f_d       = f_q;
    fv_d      = 1'b0;
    serr_d    = 1'b0;
    take      = 1'b0;
    cur_bit   = bit_cnt_q;
    cur_slot  = slot_q;
    word      = {shreg_q, d};
    at_bound  = (bit_cnt_q == '0) && (slot_q == 2'd0);

    if (bit_en) begin
      if (state_q == ST_HUNT) begin
        if (fs) begin
          state_d  = ST_RECV;
          take     = 1'b1;
          cur_bit  = '0;
          cur_slot = 2'd0;
        end
      end else begin
        if (fs && !at_bound) begin
          // Early sync: drop the partial frame and restart with this bit.
          serr_d   = 1'b1;
          take     = 1'b1;
          cur_bit  = '0;
          cur_slot = 2'd0;
        end else if (!fs && at_bound) begin
          // Missing sync: lose lock, this bit is not part of any frame.
          serr_d  = 1'b1;
          state_d = ST_HUNT;
        end else begin
          take = 1'b1;
        end
      end
    end

    if (take) begin
      shreg_d = word[W-2:0];
      if (cur_bit == LAST_BIT) begin
        bit_cnt_d = '0;
        slot_d    = cur_slot + 2'd1;
        case (cur_slot)
          2'd0:    stage_d[0] = word;
          2'd1:    stage_d[1] = word;
          2'd2:    stage_d[2] = word;
          default: begin
            f_d  = {word, stage_q[2], stage_q[1], stage_q[0]};
            fv_d = 1'b1;
          end
        endcase
      end else begin
        bit_cnt_d = cur_bit + BW'(1);
        slot_d    = cur_slot;
      end
    end
  end

  // State registers; reset clears everything including the output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      bit_cnt_q <= '0;
      slot_q    <= 2'd0;
      shreg_q   <= '0;
      stage_q   <= '0;
      f_q       <= '0;
      fv_q      <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      slot_q    <= slot_d;
      shreg_q   <= shreg_d;
      stage_q   <= stage_d;
      f_q       <= f_d;
      fv_q      <= fv_d;
      serr_q    <= serr_d;
    end
  end

  assign f           = f_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign locked      = (state_q == ST_RECV);

endmodule
